// File: rtl/up_down_mod_counter_pkg.sv
// Shared constants for the up/down modulus counter: direction encoding and
// the classification of a single enabled step.
package up_down_mod_counter_pkg;

    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

    // STEP_HOLD covers the down-count re-entry case, where an out-of-range
    // count is pulled back to max_val without raising either flag.
    typedef enum logic [2:0] {
        STEP_INC  = 3'd0,
        STEP_DEC  = 3'd1,
        STEP_WRAP = 3'd2,
        STEP_SAT  = 3'd3,
        STEP_HOLD = 3'd4
    } step_e;

endpackage : up_down_mod_counter_pkg

// File: rtl/up_down_mod_counter_next.sv
// Combinational next-count logic for one enabled step of the modulus counter.
// It knows nothing about clear, load or enable; the top level arbitrates those.
module up_down_mod_counter_next
    import up_down_mod_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             mode_i,
    input  logic             saturate_i,
    input  logic [WIDTH-1:0] max_val_i,
    output logic [WIDTH-1:0] next_count_o,
    output logic             wrap_o,
    output logic             sat_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    step_e step;

    // Classify the step; a count at or above max_val is treated as the top
    // boundary going up, and as out-of-range (re-entry) going down.
    always_comb begin
        step = STEP_HOLD;
        if (mode_i == MODE_UP) begin
            if (count_i < max_val_i) begin
                step = STEP_INC;
            end else if (!saturate_i) begin
                step = STEP_WRAP;
            end else begin
                step = STEP_SAT;
            end
        end else begin
            if (count_i > max_val_i) begin
                step = STEP_HOLD;
            end else if (count_i != '0) begin
                step = STEP_DEC;
            end else if (!saturate_i) begin
                step = STEP_WRAP;
            end else begin
                step = STEP_SAT;
            end
        end
    end

    // Map the step class to the new count and the flag values it produces.
    always_comb begin
        next_count_o = count_i;
        wrap_o       = 1'b0;
        sat_o        = 1'b0;
        unique case (step)
            STEP_INC:  next_count_o = count_i + ONE;
            STEP_DEC:  next_count_o = count_i - ONE;
            STEP_WRAP: begin
                next_count_o = (mode_i == MODE_UP) ? '0 : max_val_i;
                wrap_o       = 1'b1;
            end
            STEP_SAT: begin
                next_count_o = (mode_i == MODE_UP) ? max_val_i : '0;
                sat_o        = 1'b1;
            end
            STEP_HOLD: next_count_o = max_val_i;
            default:   next_count_o = count_i;
        endcase
    end

endmodule : up_down_mod_counter_next

// File: rtl/up_down_mod_counter.sv
// Up/down counter with programmable modulus, synchronous clear and load,
// wrap or saturate at the boundaries. Registers and control priority live
// here; the step arithmetic lives in up_down_mod_counter_next.
module up_down_mod_counter
    import up_down_mod_counter_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             saturate,
    input  logic [WIDTH-1:0] max_val,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;

    logic [WIDTH-1:0] step_count;
    logic             step_wrap;
    logic             step_sat;
    logic [WIDTH-1:0] load_clamped;

    up_down_mod_counter_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .count_i     (count_q),
        .mode_i      (mode),
        .saturate_i  (saturate),
        .max_val_i   (max_val),
        .next_count_o(step_count),
        .wrap_o      (step_wrap),
        .sat_o       (step_sat)
    );

    assign load_clamped = (load_val > max_val) ? max_val : load_val;

    // Arbitrate clear > load > en > hold; wrap is a pulse, sat persists while idle.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        sat_d   = sat_q;
        if (clear) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (load) begin
            count_d = load_clamped;
            sat_d   = 1'b0;
        end else if (en) begin
            count_d = step_count;
            wrap_d  = step_wrap;
            sat_d   = step_sat;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RST_VAL;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign sat   = sat_q;
    assign tc    = (mode == MODE_UP) ? (count_q >= max_val) : (count_q == '0);

endmodule : up_down_mod_counter
